weight_stream_sequencer: RTL
============================

// Module: weight_stream_sequencer
// PURPOSE
//  Sequences a synchronous 1-cycle-latency weight ROM (`rom`) for one dense layer.
//  On start it walks the ROM row-major: neuron 0 inputs 0..NUM_INPUTS-1, then neuron 1, and so on.
//  It presents each weight to the downstream MAC datapath with a valid/ready handshake.
//  Address regeneration absorbs backpressure, so no skid buffer is needed.
//  Sits between the layer controller (start/done) and the neuron MAC array.
// PARAMETERS
//  INT_WIDTH    8    integer bits of signed fixed-point weight
//  FRAC_WIDTH   8    fractional bits of weight
//  NUM_INPUTS   784  weights per neuron (>=1)
//  NUM_NEURONS  1    neurons in layer (>=1); ROM DEPTH = NUM_INPUTS*NUM_NEURONS
//  ADDR_WIDTH   max(1,$clog2(NUM_INPUTS*NUM_NEURONS))  derived localparam, not overridable
// PORTS
//  clock        in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  start        in   1   begin a layer pass; sampled only in IDLE
//  abort        in   1   cancel current pass; no done pulse
//  busy         out  1   high from cycle after accepted start until pass ends
//  done         out  1   one-cycle pulse after final weight handshake
//  rom_address  out  ADDR_WIDTH           to rom.address (combinational)
//  rom_data     in   INT_WIDTH+FRAC_WIDTH from rom.out (valid 1 cycle after address)
//  weight       out  signed [INT_WIDTH-1:-FRAC_WIDTH]  = rom_data passthrough
//  weight_valid out  1   weight/indices valid
//  weight_ready in   1   downstream accepts; handshake = weight_valid & weight_ready
//  input_num    out  $clog2(NUM_INPUTS) (min 1)   input index of presented weight
//  neuron_num   out  $clog2(NUM_NEURONS) (min 1)  neuron index of presented weight
//  last_input   out  1   weight_valid & input_num==NUM_INPUTS-1
//  last         out  1   last_input & neuron_num==NUM_NEURONS-1
// BEHAVIOUR
//  Reset (async assert, sync deassert by top): state=IDLE; all indices=0; busy/done/weight_valid=0.
//  Reset mid-pass: pass is dropped, no done pulse.
//  States: IDLE, STREAM.
//  Registered index `addr` tracks the presented weight; addr==neuron_num*NUM_INPUTS+input_num.
//  IDLE: rom_address=0. start=1 -> STREAM; addr, input_num, neuron_num <= 0; weight_valid, busy <= 1.
//   mem[0] is on rom_data in the same cycle weight_valid rises, so latency is 1 cycle from start.
//  STREAM: adv = weight_ready. rom_address = adv ? addr+1 : addr.
//   - Stall (!weight_ready): ROM re-reads the same address. weight and indices are held stable.
//   - adv and not last: addr+1. input_num+1; input_num wraps to 0 with neuron_num+1 at NUM_INPUTS-1.
//   - adv and last: rom_address=0 (kept in range). -> IDLE; weight_valid, busy <= 0.
//     done=1 for exactly the next cycle.
//  abort=1 in STREAM (priority over adv): -> IDLE next edge, weight_valid=0, busy=0, done=0.
//   A weight presented in that cycle is not a valid handshake even if weight_ready=1.
//  start in STREAM is ignored. start in the done cycle is accepted, giving back-to-back passes.
//  abort in IDLE is ignored. start and abort together in IDLE: start wins.
//  NUM_INPUTS=1: every weight has last_input=1. NUM_NEURONS=1: last==last_input.
//  Exactly NUM_INPUTS*NUM_NEURONS handshakes per unaborted pass, in address order.
//  The same weight is never delivered twice.
// STRUCTURE
//  Shared package nn_pkg: INT_WIDTH/FRAC_WIDTH defaults, fixed-point weight typedef, state enum.
//  Single module; the nested input/neuron counter is inline.
//  No sub-module: the rom is instantiated alongside by the parent, not inside this block.
// TESTING  (bench: NUM_INPUTS=4, NUM_NEURONS=3, rom file with mem[i]=i<<FRAC_WIDTH;
//           ready=1 unless noted)
//  1 Reset low 3 cycles mid-stream -> busy=weight_valid=done=0, rom_address=0 on release.
//  2 start pulse, ready=1 -> 12 consecutive handshakes, weight=0..11 (integer part).
//    (neuron,input) (0,0)..(2,3); last_input on 3,7,11; last on 11.
//    done 1 cycle after 11th index; busy 12 cycles.
//  3 Hold ready=0 for 5 cycles at weight 6 -> weight stays 6, indices (1,2) stable.
//    Release -> 7 next; still 12 total, no duplicates.
//  4 Random ready (50%) over 3 passes with start asserted in each done cycle
//    -> 36 handshakes, strictly ordered 0..11 x3.
//  5 abort at weight 5 with ready=1 -> weight 5 not counted; busy=0 next cycle.
//    No done pulse. A following start restarts at 0.
//  6 start held high during STREAM -> ignored; start+abort in IDLE -> pass begins.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network layer datapath.
package nn_pkg;

    // Default fixed-point split of a stored weight
    localparam int unsigned INT_WIDTH_DEF  = 8;
    localparam int unsigned FRAC_WIDTH_DEF = 8;
    localparam int unsigned WEIGHT_WIDTH_DEF = INT_WIDTH_DEF + FRAC_WIDTH_DEF;

    // Signed fixed-point weight at the default split (integer bits above bit 0)
    typedef logic signed [INT_WIDTH_DEF-1:-FRAC_WIDTH_DEF] weight_t;

    // Sequencer control states
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } seq_state_e;

    // Index width for a counter over n values, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/weight_stream_sequencer.sv
// Walks a 1-cycle-latency weight ROM row-major (neuron-major, input-minor) and
// presents each weight downstream over valid/ready. Backpressure is absorbed by
// re-reading the presented address, so the ROM output doubles as the data stage.
module weight_stream_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned INT_WIDTH   = INT_WIDTH_DEF,
    parameter int unsigned FRAC_WIDTH  = FRAC_WIDTH_DEF,
    parameter int unsigned NUM_INPUTS  = 784,
    parameter int unsigned NUM_NEURONS = 1,
    localparam int unsigned DATA_WIDTH = INT_WIDTH + FRAC_WIDTH,
    localparam int unsigned ADDR_WIDTH = clog2_min1(NUM_INPUTS * NUM_NEURONS),
    localparam int unsigned IN_WIDTH   = clog2_min1(NUM_INPUTS),
    localparam int unsigned NEU_WIDTH  = clog2_min1(NUM_NEURONS)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic                                 abort_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic        [ADDR_WIDTH-1:0]         rom_address_c_o,
    input  logic        [DATA_WIDTH-1:0]         rom_data_i,
    output logic signed [INT_WIDTH-1:-FRAC_WIDTH] weight_c_o,
    output logic                                 weight_valid_o,
    input  logic                                 weight_ready_i,
    output logic        [IN_WIDTH-1:0]           input_num_o,
    output logic        [NEU_WIDTH-1:0]          neuron_num_o,
    output logic                                 last_input_o,
    output logic                                 last_o
);

    localparam logic [IN_WIDTH-1:0]  IN_LAST  = IN_WIDTH'(NUM_INPUTS - 1);
    localparam logic [NEU_WIDTH-1:0] NEU_LAST = NEU_WIDTH'(NUM_NEURONS - 1);

    seq_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IN_WIDTH-1:0]   in_q, in_d;
    logic [NEU_WIDTH-1:0]  neu_q, neu_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last_input_q, last_input_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] rom_address_c;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort outranks the final handshake; start only counts in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (weight_ready_i && last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values and ROM address; the address leads the presented index by one on advance
    always_comb begin
        addr_d        = addr_q;
        in_d          = in_q;
        neu_d         = neu_q;
        valid_d       = valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        rom_address_c = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                rom_address_c = '0;
                if (start_i) begin
                    addr_d  = '0;
                    in_d    = '0;
                    neu_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_STREAM: begin
                if (abort_i) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (weight_ready_i) begin
                    if (last_q) begin
                        rom_address_c = '0;
                        valid_d       = 1'b0;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                    end else begin
                        addr_d        = addr_q + ADDR_WIDTH'(1);
                        rom_address_c = addr_q + ADDR_WIDTH'(1);
                        if (in_q == IN_LAST) begin
                            in_d  = '0;
                            neu_d = neu_q + NEU_WIDTH'(1);
                        end else begin
                            in_d  = in_q + IN_WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        last_input_d = valid_d && (in_d == IN_LAST);
        last_d       = last_input_d && (neu_d == NEU_LAST);
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q       <= '0;
            in_q         <= '0;
            neu_q        <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            last_input_q <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            in_q         <= in_d;
            neu_q        <= neu_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            last_input_q <= last_input_d;
            last_q       <= last_d;
        end
    end

    assign rom_address_c_o = rom_address_c;
    assign weight_c_o      = $signed(rom_data_i);
    assign weight_valid_o  = valid_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign input_num_o     = in_q;
    assign neuron_num_o    = neu_q;
    assign last_input_o    = last_input_q;
    assign last_o          = last_q;

endmodule
